// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronised, debounced start/stop and lap buttons drive
// an IDLE/RUN/LAP/PAUSE FSM and a 10 ms prescaler that steps an external BCD counter.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 1_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       cnt_max,
  output logic       count_en,
  output logic       count_clr,
  output logic       lap_load,
  output logic       disp_frz,
  output logic [1:0] state
);

  localparam int PW  = $clog2(TICK_DIV);
  localparam int DBW = $clog2(DB_CYCLES);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           btn_raw;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           level_q, level_d;
  logic [1:0]           evt_q, evt_d;
  logic [1:0][DBW-1:0]  db_cnt_q, db_cnt_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 count_en_q, count_en_d;
  logic                 count_clr_q, count_clr_d;
  logic                 lap_load_q, lap_load_d;
  logic                 disp_frz_q, disp_frz_d;
  logic                 ss_evt, lap_evt, running, wrap;

  // Bit 0 is start/stop, bit 1 is lap throughout the button path.
  assign btn_raw = {btn_lap, btn_ss};
  assign ss_evt  = evt_q[0];
  assign lap_evt = evt_q[1];
  assign running = (state_q == RUN) || (state_q == LAP);
  assign wrap    = running && (presc_q == PRESC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      evt_q    <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      evt_q    <= evt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // A level change is accepted only after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != level_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          level_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DBW'(1);
        end
      end
    end
    evt_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ss_evt) state_d = RUN;
      end
      RUN, LAP: begin
        if (ss_evt)               state_d = PAUSE;
        else if (lap_evt)         state_d = LAP;
        else if (wrap && cnt_max) state_d = PAUSE;
      end
      PAUSE: begin
        if (ss_evt)       state_d = RUN;
        else if (lap_evt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_en_d  = wrap && !cnt_max;
    count_clr_d = (state_q == PAUSE) && !ss_evt && lap_evt;
    lap_load_d  = running && !ss_evt && lap_evt;
    disp_frz_d  = (state_d == LAP);
  end

  // The prescaler phase survives PAUSE so a resumed run keeps its 10 ms grid.
  always_comb begin
    if ((state_q == IDLE) || (state_d == IDLE)) begin
      presc_d = '0;
    end else if (running) begin
      presc_d = wrap ? '0 : presc_q + PW'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
      lap_load_q  <= 1'b0;
      disp_frz_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      count_en_q  <= count_en_d;
      count_clr_q <= count_clr_d;
      lap_load_q  <= lap_load_d;
      disp_frz_q  <= disp_frz_d;
    end
  end

  assign count_en  = count_en_q;
  assign count_clr = count_clr_q;
  assign lap_load  = lap_load_q;
  assign disp_frz  = disp_frz_q;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (TICK_DIV=4, DB_CYCLES=3) against a
// behavioural stopwatch model stepped on every clock edge.
module tb_stopwatch_ctrl;

  localparam int TICK = 4;
  localparam int DB   = 3;

  logic       clk, reset, btnSs, btnLap, cntMax;
  logic       countEn, countClr, lapLoad, dispFrz;
  logic [1:0] state;
  int         compared   = 0;
  int         mismatched = 0;

  stopwatch_ctrl #(.TICK_DIV(TICK), .DB_CYCLES(DB)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_ss   (btnSs),
    .btn_lap  (btnLap),
    .cnt_max  (cntMax),
    .count_en (countEn),
    .count_clr(countClr),
    .lap_load (lapLoad),
    .disp_frz (dispFrz),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: raw buttons seen two edges late, a press accepted after
  // DB disagreeing samples and acted on one edge later, then the stopwatch rules.
  typedef struct packed {
    logic [1:0]      st;
    logic [7:0]      presc;
    logic            en, clr, load, frz;
    logic [3:0]      dly;
    logic [1:0]      level;
    logic [1:0]      evt;
    logic [1:0][7:0] run;
  } model_t;

  model_t mdl;

  function automatic model_t stepModel(input model_t m, input logic ssRaw,
                                       input logic lapRaw, input logic cm);
    model_t     n;
    logic [1:0] sIn;
    logic       running, wrap;
    n       = m;
    running = (m.st == 2'b01) || (m.st == 2'b10);
    wrap    = running && (m.presc == 8'(TICK - 1));
    n.en    = wrap && !cm;
    n.clr   = 1'b0;
    n.load  = 1'b0;
    if (m.evt[0]) begin
      n.st = ((m.st == 2'b00) || (m.st == 2'b11)) ? 2'b01 : 2'b11;
    end else if (m.evt[1] && running) begin
      n.st   = 2'b10;
      n.load = 1'b1;
    end else if (m.evt[1] && (m.st == 2'b11)) begin
      n.st  = 2'b00;
      n.clr = 1'b1;
    end else if (wrap && cm) begin
      n.st = 2'b11;
    end
    if ((m.st == 2'b00) || (n.st == 2'b00)) n.presc = 8'd0;
    else if (running) n.presc = 8'((int'(m.presc) + 1) % TICK);
    n.frz = (n.st == 2'b10);
    sIn   = m.dly[3:2];
    n.dly = {m.dly[1:0], lapRaw, ssRaw};
    n.evt = 2'b00;
    for (int b = 0; b < 2; b++) begin
      if (sIn[b] == m.level[b]) begin
        n.run[b] = 8'd0;
      end else if (int'(m.run[b]) + 1 == DB) begin
        n.level[b] = sIn[b];
        n.run[b]   = 8'd0;
        n.evt[b]   = sIn[b];
      end else begin
        n.run[b] = m.run[b] + 8'd1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) mdl <= '0;
    else       mdl <= stepModel(mdl, btnSs, btnLap, cntMax);
  end

  wire [5:0] dutOut = {state, countEn, countClr, lapLoad, dispFrz};
  wire [5:0] expOut = {mdl.st, mdl.en, mdl.clr, mdl.load, mdl.frz};

  task automatic test_reset();
    reset = 1'b1;
    #1;
    compared++;
    if (dutOut !== 6'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_async got %b expected %b", dutOut, 6'b0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compared++;
      if (dutOut !== expOut) begin
        mismatched++;
        $display("[TB] FAIL reset_idle cyc=%0d got %b expected %b", i, dutOut, expOut);
      end
    end
  endtask

  task automatic test_start();
    int firstRun = -1;
    int enSeen   = 0;
    btnSs = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      compared++;
      if (dutOut !== expOut) begin
        mismatched++;
        $display("[TB] FAIL start_track cyc=%0d got %b expected %b", i, dutOut, expOut);
      end
      if (firstRun < 0 && state == 2'b01) firstRun = i;
    end
    compared++;
    if (firstRun < 0 || firstRun + 1 > 6) begin
      mismatched++;
      $display("[TB] FAIL start_latency got %0d cycles expected <= 6", firstRun + 1);
    end
    btnSs = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      compared++;
      if (dutOut !== expOut) begin
        mismatched++;
        $display("[TB] FAIL start_release cyc=%0d got %b expected %b", i, dutOut, expOut);
      end
      if (countEn) enSeen++;
    end
    compared++;
    if (enSeen != 16 / TICK || state !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL start_cadence got %0d pulses state %b expected %0d pulses state 01",
               enSeen, state, 16 / TICK);
    end
  endtask

  task automatic test_glitch();
    int len    = $urandom_range(1, DB - 1);
    int enSeen = 0;
    btnSs = 1'b1;
    for (int i = 0; i < len + 16; i++) begin
      @(negedge clk);
      compared++;
      if (dutOut !== expOut) begin
        mismatched++;
        $display("[TB] FAIL glitch_track cyc=%0d got %b expected %b", i, dutOut, expOut);
      end
      if (i >= len && countEn) enSeen++;
      if (i == len - 1) btnSs = 1'b0;
    end
    compared++;
    if (state !== 2'b01 || enSeen != 16 / TICK) begin
      mismatched++;
      $display("[TB] FAIL glitch_effect got state %b pulses %0d expected state 01 pulses %0d",
               state, enSeen, 16 / TICK);
    end
  endtask

  task automatic test_pause_phase();
    int guard    = 0;
    int firstRun = -1;
    int gap      = -1;
    while (mdl.presc != 8'd1 && guard < 8) begin
      @(negedge clk);
      guard++;
      compared++;
      if (dutOut !== expOut) begin
        mismatched++;
        $display("[TB] FAIL pause_align got %b expected %b", dutOut, expOut);
      end
    end
    btnSs = 1'b1;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      compared++;
      if (dutOut !== expOut) begin
        mismatched++;
        $display("[TB] FAIL pause_hold cyc=%0d got %b expected %b", i, dutOut, expOut);
      end
      if (i == 4) btnSs = 1'b0;
    end
    compared++;
    if (state !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL pause_state got %b expected 11", state);
    end
    btnSs = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      compared++;
      if (dutOut !== expOut) begin
        mismatched++;
        $display("[TB] FAIL resume_track cyc=%0d got %b expected %b", i, dutOut, expOut);
      end
      if (firstRun >= 0 && gap < 0 && countEn) gap = i - firstRun;
      if (firstRun < 0 && state == 2'b01) firstRun = i;
      if (i == 4) btnSs = 1'b0;
    end
    compared++;
    if (gap != 1) begin
      mismatched++;
      $display("[TB] FAIL resume_phase got gap %0d expected 1", gap);
    end
  endtask

  task automatic test_lap();
    for (int k = 0; k < 2; k++) begin
      int loads  = 0;
      int enSeen = 0;
      btnLap = 1'b1;
      for (int i = 0; i < 14; i++) begin
        @(negedge clk);
        compared++;
        if (dutOut !== expOut) begin
          mismatched++;
          $display("[TB] FAIL lap_track k=%0d cyc=%0d got %b expected %b", k, i, dutOut, expOut);
        end
        if (lapLoad) loads++;
        if (countEn) enSeen++;
        if (i == 4) btnLap = 1'b0;
      end
      compared++;
      if (loads != 1 || state !== 2'b10 || dispFrz !== 1'b1 || enSeen == 0) begin
        mismatched++;
        $display("[TB] FAIL lap_split k=%0d got loads %0d state %b frz %b en %0d expected 1/10/1/>0",
                 k, loads, state, dispFrz, enSeen);
      end
    end
  endtask

  task automatic test_pause_clear();
    int clears = 0;
    int loads  = 0;
    btnSs = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      compared++;
      if (dutOut !== expOut) begin
        mismatched++;
        $display("[TB] FAIL stop_track cyc=%0d got %b expected %b", i, dutOut, expOut);
      end
      if (i == 4) btnSs = 1'b0;
    end
    compared++;
    if (state !== 2'b11 || dispFrz !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stop_from_lap got state %b frz %b expected 11 0", state, dispFrz);
    end
    btnLap = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      compared++;
      if (dutOut !== expOut) begin
        mismatched++;
        $display("[TB] FAIL clear_track cyc=%0d got %b expected %b", i, dutOut, expOut);
      end
      if (countClr) clears++;
      if (i == 4) btnLap = 1'b0;
    end
    compared++;
    if (clears != 1 || state !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL clear_idle got clears %0d state %b expected 1 00", clears, state);
    end
    btnSs  = 1'b1;
    btnLap = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      compared++;
      if (dutOut !== expOut) begin
        mismatched++;
        $display("[TB] FAIL both_track cyc=%0d got %b expected %b", i, dutOut, expOut);
      end
      if (lapLoad) loads++;
      if (i == 4) begin
        btnSs  = 1'b0;
        btnLap = 1'b0;
      end
    end
    compared++;
    if (state !== 2'b01 || loads != 0) begin
      mismatched++;
      $display("[TB] FAIL both_priority got state %b loads %0d expected 01 0", state, loads);
    end
  endtask

  task automatic test_saturation();
    int enSeen = 0;
    int cyc    = 0;
    cntMax = 1'b1;
    while (state !== 2'b11 && cyc < 12) begin
      @(negedge clk);
      cyc++;
      compared++;
      if (dutOut !== expOut) begin
        mismatched++;
        $display("[TB] FAIL sat_track cyc=%0d got %b expected %b", cyc, dutOut, expOut);
      end
      if (countEn) enSeen++;
    end
    compared++;
    if (state !== 2'b11 || enSeen != 0) begin
      mismatched++;
      $display("[TB] FAIL sat_pause got state %b pulses %0d expected 11 0", state, enSeen);
    end
    cntMax = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int firstRun = -1;
    int gap      = -1;
    btnSs = 1'b1;
    for (int i = 0; i < 14 + int'($urandom_range(0, 6)); i++) begin
      @(negedge clk);
      compared++;
      if (dutOut !== expOut) begin
        mismatched++;
        $display("[TB] FAIL rerun_track cyc=%0d got %b expected %b", i, dutOut, expOut);
      end
      if (i == 4) btnSs = 1'b0;
    end
    btnLap = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    compared++;
    if (dutOut !== 6'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_midrun got %b expected %b", dutOut, 6'b0);
    end
    @(negedge clk);
    btnLap = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    btnSs = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      compared++;
      if (dutOut !== expOut) begin
        mismatched++;
        $display("[TB] FAIL postreset_track cyc=%0d got %b expected %b", i, dutOut, expOut);
      end
      if (firstRun >= 0 && gap < 0 && countEn) gap = i - firstRun;
      if (firstRun < 0 && state == 2'b01) firstRun = i;
      if (i == 4) btnSs = 1'b0;
    end
    compared++;
    if (gap != TICK) begin
      mismatched++;
      $display("[TB] FAIL postreset_phase got gap %0d expected %0d", gap, TICK);
    end
  endtask

  task automatic test_random();
    int holdSs  = 0;
    int holdLap = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      compared++;
      if (dutOut !== expOut) begin
        mismatched++;
        $display("[TB] FAIL random cyc=%0d got %b expected %b", i, dutOut, expOut);
      end
      if (holdSs == 0) begin
        btnSs  = 1'($urandom_range(0, 1));
        holdSs = $urandom_range(1, 10);
      end else holdSs--;
      if (holdLap == 0) begin
        btnLap  = 1'($urandom_range(0, 1));
        holdLap = $urandom_range(1, 10);
      end else holdLap--;
      cntMax = ($urandom_range(0, 29) == 0) ? ~cntMax : cntMax;
    end
  endtask

  initial begin
    reset  = 1'b0;
    btnSs  = 1'b0;
    btnLap = 1'b0;
    cntMax = 1'b0;
    #1;
    test_reset();
    test_start();
    test_glitch();
    test_pause_phase();
    test_lap();
    test_pause_clear();
    test_saturation();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
